rv32_alu_issue: RTL and testbench

- Decode/issue stage of the rv32 3-stage pipeline; feeds the execute-stage ALU (data1, data2, 4-bit op).
- Accepts fetched instructions through a valid/ready handshake, decodes integer ALU, LUI/AUIPC and branch instructions, and reads the register file.
- Applies writeback forwarding and a one-entry RAW stall.
- Presents a registered operand/op bundle to execute through a second valid/ready handshake.

---
 rtl/rv32_alu_issue.sv | 212 +++++++++++++++++++++
 tb/tb_rv32_alu_issue.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu_issue.sv
// Decode/issue stage of the rv32 3-stage pipeline: decodes ALU, LUI/AUIPC and
// branch instructions, forwards writeback data and issues a registered ALU bundle.
module rv32_alu_issue #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data1,
  output logic [XLEN-1:0] out_data2,
  output logic [3:0]      out_op,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_is_branch,
  output logic [31:0]     out_br_target,
  output logic [31:0]     out_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_EQ  = 4'd6;
  localparam logic [3:0] ALU_NE  = 4'd7;
  localparam logic [3:0] ALU_LTU = 4'd9;
  localparam logic [3:0] ALU_GEU = 4'd10;

  // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
  localparam logic [XLEN-1:0] SIGN_BIAS = {1'b1, {(XLEN-1){1'b0}}};

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_u;
  logic [31:0]     w_imm_b;
  logic            w_legal;
  logic            w_bias;
  logic            w_is_branch;
  logic [3:0]      w_op;
  logic [XLEN-1:0] w_d1;
  logic [XLEN-1:0] w_d2;
  logic            w_hazard;
  logic            w_fire;

  logic            r_valid;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_data1;
  logic [XLEN-1:0] r_data2;
  logic [4:0]      r_rd;
  logic            r_wb_en;
  logic            r_is_branch;
  logic [31:0]     r_br_target;
  logic [31:0]     r_pc;
  logic            r_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign w_use_rs1 = (w_opcode == OPC_OP) || (w_opcode == OPC_OPIMM) || (w_opcode == OPC_BRANCH);
  assign w_use_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_BRANCH);

  assign w_src1 = (rs1_addr == 5'd0) ? '0 :
                  (fwd_valid && fwd_rd == rs1_addr) ? fwd_data : rs1_data;
  assign w_src2 = (rs2_addr == 5'd0) ? '0 :
                  (fwd_valid && fwd_rd == rs2_addr) ? fwd_data : rs2_data;

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  // NOTE: every signal gets a default at the top so no path through the case infers a latch.
  always_comb begin
    w_legal     = 1'b0;
    w_bias      = 1'b0;
    w_is_branch = 1'b0;
    w_op        = ALU_ADD;
    w_d1        = w_src1;
    w_d2        = w_src2;
    case (w_opcode)
      OPC_OP: begin
        w_legal = 1'b1;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: w_op = ALU_ADD;
          {7'h20, 3'b000}: w_op = ALU_SUB;
          {7'h00, 3'b111}: w_op = ALU_AND;
          {7'h00, 3'b110}: w_op = ALU_OR;
          {7'h00, 3'b100}: w_op = ALU_XOR;
          {7'h00, 3'b011}: w_op = ALU_LTU;
          {7'h00, 3'b010}: begin w_op = ALU_LTU; w_bias = 1'b1; end
          default:         w_legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        w_legal = 1'b1;
        w_d2    = w_imm_i;
        case (w_funct3)
          3'b000:  w_op = ALU_ADD;
          3'b111:  w_op = ALU_AND;
          3'b110:  w_op = ALU_OR;
          3'b100:  w_op = ALU_XOR;
          3'b011:  w_op = ALU_LTU;
          3'b010:  begin w_op = ALU_LTU; w_bias = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_d1    = '0;
        w_d2    = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_d1    = in_pc;
        w_d2    = w_imm_u;
      end
      OPC_BRANCH: begin
        w_legal     = 1'b1;
        w_is_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_op = ALU_EQ;
          3'b001:  w_op = ALU_NE;
          3'b100:  begin w_op = ALU_LTU; w_bias = 1'b1; end
          3'b101:  begin w_op = ALU_GEU; w_bias = 1'b1; end
          3'b110:  w_op = ALU_LTU;
          3'b111:  w_op = ALU_GEU;
          default: w_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // The held result reaches the operands only through fwd a cycle after handoff, so stall even if out_ready.
  assign w_hazard = r_valid && r_wb_en && (r_rd != 5'd0) &&
                    ((w_use_rs1 && r_rd == rs1_addr) || (w_use_rs2 && r_rd == rs2_addr));

  assign in_ready = rst_n && !flush && !w_hazard && (!r_valid || out_ready);
  assign w_fire   = in_valid && in_ready;

  // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_op        <= ALU_ADD;
      r_data1     <= '0;
      r_data2     <= '0;
      r_rd        <= 5'd0;
      r_wb_en     <= 1'b0;
      r_is_branch <= 1'b0;
      r_br_target <= 32'd0;
      r_pc        <= RESET_PC;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid     <= 1'b1;
      r_op        <= w_legal ? w_op : ALU_ADD;
      r_data1     <= !w_legal ? '0 : (w_bias ? (w_d1 ^ SIGN_BIAS) : w_d1);
      r_data2     <= !w_legal ? '0 : (w_bias ? (w_d2 ^ SIGN_BIAS) : w_d2);
      r_rd        <= (w_legal && !w_is_branch) ? in_instr[11:7] : 5'd0;
      r_wb_en     <= w_legal && !w_is_branch;
      r_is_branch <= w_legal && w_is_branch;
      r_br_target <= (w_legal && w_is_branch) ? (in_pc + w_imm_b) : 32'd0;
      r_pc        <= in_pc;
      r_illegal   <= !w_legal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign out_op        = r_op;
  assign out_data1     = r_data1;
  assign out_data2     = r_data2;
  assign out_rd        = r_rd;
  assign out_wb_en     = r_wb_en;
  assign out_is_branch = r_is_branch;
  assign out_br_target = r_br_target;
  assign out_pc        = r_pc;
  assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Self-checking bench for rv32_alu_issue: directed scenarios plus a randomized
// run checked against a mnemonic-level reference model.
module tb_rv32_alu_issue;

  localparam logic [31:0] RST_PC     = 32'h0000_1000;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        ill;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
  } bundle_t;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data1, out_data2, out_br_target, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_wb_en, out_is_branch, out_illegal;

  logic [31:0] regs [32];
  int n_chk  = 0;
  int n_fail = 0;

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  rv32_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2), .out_op(out_op), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_is_branch(out_is_branch), .out_br_target(out_br_target),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  // Architectural operand value as execute should see it.
  function automatic logic [31:0] src(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (fwd_valid && fwd_rd == r) return fwd_data;
    return regs[r];
  endfunction

  function automatic bundle_t model(logic [31:0] ins, logic [31:0] pc);
    bundle_t     e;
    string       mn;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_u, imm_b;
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = 32'($signed(ins[31:20]));
    imm_u = {ins[31:12], 12'h000};
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    mn = "";
    case (ins[6:0])
      OPC_OP:
        if (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0))
          case (f3)
            3'd0: mn = (f7 == 7'h20) ? "SUB" : "ADD";
            3'd2: mn = "SLT";
            3'd3: mn = "SLTU";
            3'd4: mn = "XOR";
            3'd6: mn = "OR";
            3'd7: mn = "AND";
            default: ;
          endcase
      OPC_OPIMM:
        case (f3)
          3'd0: mn = "ADDI";
          3'd2: mn = "SLTI";
          3'd3: mn = "SLTIU";
          3'd4: mn = "XORI";
          3'd6: mn = "ORI";
          3'd7: mn = "ANDI";
          default: ;
        endcase
      OPC_LUI:   mn = "LUI";
      OPC_AUIPC: mn = "AUIPC";
      OPC_BRANCH:
        case (f3)
          3'd0: mn = "BEQ";
          3'd1: mn = "BNE";
          3'd4: mn = "BLT";
          3'd5: mn = "BGE";
          3'd6: mn = "BLTU";
          3'd7: mn = "BGEU";
          default: ;
        endcase
      default: ;
    endcase
    e     = '0;
    e.pc  = pc;
    e.ill = (mn == "");
    e.d1  = src(ins[19:15]);
    e.d2  = (ins[6:0] == OPC_OPIMM) ? imm_i : src(ins[24:20]);
    if (mn == "LUI")   begin e.d1 = 32'd0; e.d2 = imm_u; end
    if (mn == "AUIPC") begin e.d1 = pc;    e.d2 = imm_u; end
    case (mn)
      "SUB":                                      e.op = 4'd1;
      "AND", "ANDI":                              e.op = 4'd2;
      "OR", "ORI":                                e.op = 4'd3;
      "XOR", "XORI":                              e.op = 4'd4;
      "BEQ":                                      e.op = 4'd6;
      "BNE":                                      e.op = 4'd7;
      "SLT", "SLTI", "SLTU", "SLTIU", "BLT", "BLTU": e.op = 4'd9;
      "BGE", "BGEU":                              e.op = 4'd10;
      default:                                    e.op = 4'd0;
    endcase
    if (mn == "SLT" || mn == "SLTI" || mn == "BLT" || mn == "BGE") begin
      e.d1 = e.d1 + 32'h8000_0000;
      e.d2 = e.d2 + 32'h8000_0000;
    end
    e.br  = !e.ill && (ins[6:0] == OPC_BRANCH);
    e.wb  = !e.ill && !e.br;
    e.rd  = e.wb ? ins[11:7] : 5'd0;
    e.tgt = e.br ? pc + imm_b : 32'd0;
    if (e.ill) begin e.d1 = 32'd0; e.d2 = 32'd0; end
    return e;
  endfunction

  // Fields the design is free to choose (operands of illegal ops, target of non-branches) are cleared.
  function automatic bundle_t mask(bundle_t b, bundle_t e);
    if (e.ill) begin b.d1 = '0; b.d2 = '0; b.rd = '0; b.tgt = '0; end
    else if (!e.br) b.tgt = '0;
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    w  = $urandom;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    case ($urandom_range(0, 5))
      0: w = enc_r(f7, r2, r1, f3, rd, OPC_OP);
      1: w = enc_i(12'($urandom), r1, f3, rd, OPC_OPIMM);
      2: w = enc_u(20'($urandom), rd, OPC_LUI);
      3: w = enc_u(20'($urandom), rd, OPC_AUIPC);
      4: w = enc_b(13'($urandom), r2, r1, f3);
      default: ;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    fwd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h40;
    in_instr = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPC_OPIMM);
    tick(); tick();
    n_chk++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready_valid: got %b want 00", {in_ready, out_valid});
    end
    n_chk++;
    if (out_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", out_pc, RST_PC); end
    n_chk++;
    if ({out_op, out_data1, out_data2, out_rd, out_wb_en, out_is_branch, out_illegal, out_br_target} !== '0) begin
      n_fail++; $display("FAIL reset_fields: op %0d d1 %h d2 %h rd %0d tgt %h want all zero",
                         out_op, out_data1, out_data2, out_rd, out_br_target);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if ({out_valid, out_op, out_data1, out_data2, out_rd, out_wb_en, out_illegal, out_pc} !==
        {1'b1, 4'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'h40}) begin
      n_fail++; $display("FAIL first_addi: v %b op %0d d1 %h d2 %h rd %0d pc %h want 1 0 0 5 1 40",
                         out_valid, out_op, out_data1, out_data2, out_rd, out_pc);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++;
    if ({out_valid, out_pc} !== {1'b0, RST_PC}) begin
      n_fail++; $display("FAIL midop_reset: valid %b pc %h want 0 %h", out_valid, out_pc, RST_PC);
    end
  endtask

  task automatic test_slt();
    idle();
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'h1;
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h200;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd5, OPC_OP);
    tick();
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd6, OPC_OP);
    n_chk++;
    if ({out_valid, out_op, out_data1, out_data2, out_rd} !== {1'b1, 4'd9, 32'h7FFF_FFFF, 32'h8000_0001, 5'd5}) begin
      n_fail++; $display("FAIL slt: op %0d d1 %h d2 %h rd %0d want 9 7fffffff 80000001 5",
                         out_op, out_data1, out_data2, out_rd);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_op, out_data1, out_data2, out_rd} !== {1'b1, 4'd9, 32'hFFFF_FFFF, 32'h1, 5'd6}) begin
      n_fail++; $display("FAIL sltu: op %0d d1 %h d2 %h rd %0d want 9 ffffffff 1 6",
                         out_op, out_data1, out_data2, out_rd);
    end
    tick();
  endtask

  task automatic test_raw_stall();
    idle();
    regs[1] = 32'd3; regs[2] = 32'd4; regs[3] = 32'h55;
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP);
    tick();
    in_instr = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4, OPC_OP);
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_held: in_ready %b want 0", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_handoff: in_ready %b want 0", in_ready); end
    tick();
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'd7;
    #1;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL raw_fwd_accept: valid/ready %b want 01", {out_valid, in_ready});
    end
    tick();
    in_valid = 1'b0; fwd_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_op, out_data1, out_data2, out_rd} !== {1'b1, 4'd0, 32'd7, 32'd7, 5'd4}) begin
      n_fail++; $display("FAIL raw_fwd_data: d1 %h d2 %h rd %0d want 7 7 4", out_data1, out_data2, out_rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = enc_i(12'd9, 5'd0, 3'b000, 5'd7, OPC_OPIMM);
    tick();
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd8, OPC_OP);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if ({in_ready, out_valid, out_op, out_data1, out_data2, out_rd} !==
          {1'b0, 1'b1, 4'd0, 32'd0, 32'd9, 5'd7}) begin
        n_fail++; $display("FAIL backpressure_hold[%0d]: rdy %b v %b d2 %h rd %0d want 0 1 9 7",
                           i, in_ready, out_valid, out_data2, out_rd);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release: in_ready %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_op, out_data1, out_data2, out_rd} !== {1'b1, 4'd4, 32'd3, 32'd4, 5'd8}) begin
      n_fail++; $display("FAIL backpressure_next: op %0d d1 %h d2 %h rd %0d want 4 3 4 8",
                         out_op, out_data1, out_data2, out_rd);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    idle();
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h100;
    in_instr = enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001);
    tick();
    n_chk++;
    if ({out_valid, out_op, out_is_branch, out_wb_en, out_rd, out_br_target, out_pc} !==
        {1'b1, 4'd7, 1'b1, 1'b0, 5'd0, 32'h0000_00F8, 32'h100}) begin
      n_fail++; $display("FAIL bne: op %0d br %b wb %b rd %0d tgt %h pc %h want 7 1 0 0 f8 100",
                         out_op, out_is_branch, out_wb_en, out_rd, out_br_target, out_pc);
    end
    flush = 1'b1;
    in_instr = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPC_OPIMM);
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: in_ready %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: out_valid %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_illegal_lui();
    idle();
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = enc_r(7'h00, 5'd3, 5'd2, 3'b001, 5'd1, OPC_OP);
    tick();
    in_instr = enc_u(20'hABCDE, 5'd5, OPC_LUI);
    n_chk++;
    if ({out_valid, out_illegal, out_op, out_wb_en, out_is_branch} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sll_illegal: v %b ill %b op %0d wb %b br %b want 1 1 0 0 0",
                         out_valid, out_illegal, out_op, out_wb_en, out_is_branch);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if ({out_valid, out_illegal, out_op, out_data1, out_data2, out_rd, out_wb_en} !==
        {1'b1, 1'b0, 4'd0, 32'd0, 32'hABCD_E000, 5'd5, 1'b1}) begin
      n_fail++; $display("FAIL lui: ill %b d1 %h d2 %h rd %0d wb %b want 0 0 abcde000 5 1",
                         out_illegal, out_data1, out_data2, out_rd, out_wb_en);
    end
    tick();
  endtask

  task automatic test_random();
    logic       m_valid;
    bundle_t    m_b, got;
    logic       exp_rdy, hz, u1, u2;
    logic [4:0] k;
    idle();
    m_valid = 1'b0;
    m_b     = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      fwd_valid = ($urandom_range(0, 1) == 1);
      fwd_rd    = 5'($urandom_range(0, 7));
      fwd_data  = $urandom;
      k         = 5'($urandom_range(1, 7));
      regs[k]   = $urandom;
      #1;
      u1 = (in_instr[6:0] == OPC_OP) || (in_instr[6:0] == OPC_OPIMM) || (in_instr[6:0] == OPC_BRANCH);
      u2 = (in_instr[6:0] == OPC_OP) || (in_instr[6:0] == OPC_BRANCH);
      hz = m_valid && m_b.wb && (m_b.rd != 5'd0) &&
           ((u1 && m_b.rd == in_instr[19:15]) || (u2 && m_b.rd == in_instr[24:20]));
      exp_rdy = !flush && !hz && (!m_valid || out_ready);
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b instr %h", c, in_ready, exp_rdy, in_instr);
      end
      n_chk++;
      if ({rs1_addr, rs2_addr} !== {in_instr[19:15], in_instr[24:20]}) begin
        n_fail++; $display("FAIL rand_rsaddr[%0d]: got %h want %h", c, {rs1_addr, rs2_addr},
                           {in_instr[19:15], in_instr[24:20]});
      end
      n_chk++;
      if (out_valid !== m_valid) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        got = {out_illegal, out_op, out_data1, out_data2, out_rd, out_wb_en, out_is_branch, out_br_target, out_pc};
        n_chk++;
        if (mask(got, m_b) !== mask(m_b, m_b)) begin
          n_fail++; $display("FAIL rand_bundle[%0d]: got %h want %h", c, mask(got, m_b), mask(m_b, m_b));
        end
      end
      if (flush) m_valid = 1'b0;
      else if (in_valid && exp_rdy) begin m_b = model(in_instr, in_pc); m_valid = 1'b1; end
      else if (out_ready) m_valid = 1'b0;
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
    regs[0] = 32'hDEAD_BEEF;
    test_reset();
    test_slt();
    test_raw_stall();
    test_backpressure();
    test_branch_flush();
    test_illegal_lui();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
